// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle MIPS core slice.
// Holds the opcode and funct encodings, the 3-bit ALU control codes,
// the main control FSM state enum and small ALU helper functions.
// The bne opcode is only decoded when MC_DATAPATH_BNE_EN is defined.
package mc_pkg;

    // Opcodes (ir[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (ir[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU control encoding used throughout this core
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_REX,
        S_RWB,
        S_AEX,
        S_AWB,
        S_BEQ,
        S_JMP,
        S_HALT
    } state_e;

    // Map an R-type funct to {supported, alu_ctl}; unsupported codes return supported=0.
    function automatic logic [3:0] alu_decode(input logic [5:0] funct);
        logic [3:0] res;
        case (funct)
            FN_ADD:  res = {1'b1, ALU_ADD};
            FN_SUB:  res = {1'b1, ALU_SUB};
            FN_AND:  res = {1'b1, ALU_AND};
            FN_OR:   res = {1'b1, ALU_OR};
            FN_SLT:  res = {1'b1, ALU_SLT};
            default: res = {1'b0, ALU_ADD};
        endcase
        return res;
    endfunction

    // 32-bit ALU; arithmetic wraps, slt is a signed compare.
    function automatic logic [31:0] alu_op(input logic [2:0] ctl, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] res;
        case (ctl)
            ALU_ADD: res = a + b;
            ALU_SUB: res = a - b;
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_SLT: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: res = 32'd0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// mc_regfile: 32 x 32-bit register file, two asynchronous read ports and
// one synchronous write port. Register 0 always reads as zero and ignores writes.
// Ports: clk, reset (async, active-high clear), ra1/ra2 read addresses,
// rd1/rd2 read data, we/wa/wd write enable, address and data.
module mc_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);

    logic [31:0] rf_q [0:31];

    // Write port with asynchronous clear; entry 0 is never written so it stays zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 32'd0; i < 32'd32; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else if (we && (wa != 5'd0)) begin
            rf_q[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : rf_q[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : rf_q[ra2];

endmodule

// File: rtl/mc_datapath.sv
// mc_datapath: multicycle MIPS datapath and main control FSM sharing one
// request/ready memory port for instruction fetch and data access.
// Parameters: ADDR_W (PC/address width), RESET_PC (word-aligned reset PC).
// Ports: clk, reset (async active-high); mem_req/mem_we/mem_addr/mem_wdata
// request side, mem_rdata/mem_ready response side; pc, retire (one pulse per
// completed instruction), halted (sticky after an illegal opcode/funct).
// Optional feature: define MC_DATAPATH_BNE_EN to decode bne (inverted beq).
module mc_datapath
    import mc_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              retire,
    output logic              halted
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [31:0]         ir_q, ir_d, mdr_q, mdr_d, a_q, a_d, b_q, b_d, aluout_q, aluout_d;
    logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                retire_q, retire_d, halted_q, halted_d;

    logic [5:0]          opcode_s, funct_s;
    logic [4:0]          rs_s, rt_s, rd_s;
    logic [31:0]         signimm_s, pc_ext_s, jump_s, diff_s, rd1_s, rd2_s, rf_wd_s;
    logic [ADDR_W-1:0]   aluout_trunc_s;
    logic [4:0]          rf_wa_s;
    logic                rf_we_s, mem_done_s, alu_ok_s, zero_s, take_s;
    logic [2:0]          alu_ctl_s;

    assign opcode_s   = ir_q[31:26];
    assign rs_s       = ir_q[25:21];
    assign rt_s       = ir_q[20:16];
    assign rd_s       = ir_q[15:11];
    assign funct_s    = ir_q[5:0];
    assign signimm_s  = {{16{ir_q[15]}}, ir_q[15:0]};
    assign pc_ext_s   = 32'(pc_q);
    assign jump_s     = {pc_ext_s[31:28], ir_q[25:0], 2'b00};
    assign mem_done_s = mem_req_q & mem_ready;
    assign {alu_ok_s, alu_ctl_s} = alu_decode(funct_s);
    assign diff_s     = a_q - b_q;
    assign zero_s     = (diff_s == 32'd0);
`ifdef MC_DATAPATH_BNE_EN
    assign take_s     = (opcode_s == OP_BNE) ? ~zero_s : zero_s;
`else
    assign take_s     = zero_s;
`endif
    assign aluout_trunc_s = ADDR_W'(aluout_d);

    mc_regfile u_regfile (
        .clk   (clk),
        .reset (reset),
        .ra1   (rs_s),
        .ra2   (rt_s),
        .rd1   (rd1_s),
        .rd2   (rd2_s),
        .we    (rf_we_s),
        .wa    (rf_wa_s),
        .wd    (rf_wd_s)
    );

    // Main control FSM next-state and datapath register enables.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        mdr_d    = mdr_q;
        a_d      = a_q;
        b_d      = b_q;
        aluout_d = aluout_q;
        rf_we_s  = 1'b0;
        rf_wa_s  = rt_s;
        rf_wd_s  = aluout_q;
        case (state_q)
            S_FETCH: begin
                if (mem_done_s) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(32'd4);
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                a_d      = rd1_s;
                b_d      = rd2_s;
                aluout_d = pc_ext_s + (signimm_s << 2);
                case (opcode_s)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_REX;
                    OP_BEQ:       state_d = S_BEQ;
`ifdef MC_DATAPATH_BNE_EN
                    OP_BNE:       state_d = S_BEQ;
`endif
                    OP_ADDI:      state_d = S_AEX;
                    OP_J:         state_d = S_JMP;
                    default:      state_d = S_HALT;
                endcase
            end
            S_MEMADR: begin
                aluout_d = a_q + signimm_s;
                state_d  = (opcode_s == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                if (mem_done_s) begin
                    mdr_d   = mem_rdata;
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMWB: begin
                rf_we_s = 1'b1;
                rf_wd_s = mdr_q;
                state_d = S_FETCH;
            end
            S_MEMWR: begin
                if (mem_done_s) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_REX: begin
                // Unsupported funct codes halt without touching aluout or the regfile.
                if (alu_ok_s) begin
                    aluout_d = alu_op(alu_ctl_s, a_q, b_q);
                    state_d  = S_RWB;
                end else begin
                    state_d  = S_HALT;
                end
            end
            S_RWB: begin
                rf_we_s = 1'b1;
                rf_wa_s = rd_s;
                state_d = S_FETCH;
            end
            S_AEX: begin
                aluout_d = a_q + signimm_s;
                state_d  = S_AWB;
            end
            S_AWB: begin
                rf_we_s = 1'b1;
                state_d = S_FETCH;
            end
            S_BEQ: begin
                if (take_s) begin
                    pc_d = ADDR_W'(aluout_q);
                end else begin
                    pc_d = pc_q;
                end
                state_d = S_FETCH;
            end
            S_JMP: begin
                pc_d    = ADDR_W'(jump_s);
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    // Memory port and status outputs are computed from the next state so they leave a flop.
    // A request stays asserted, with stable address/data, until the cycle that completes it.
    always_comb begin
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        retire_d    = 1'b0;
        case (state_d)
            S_FETCH: begin
                mem_req_d  = 1'b1;
                mem_addr_d = {pc_d[ADDR_W-1:2], 2'b00};
            end
            S_MEMRD: begin
                mem_req_d  = 1'b1;
                mem_addr_d = {aluout_trunc_s[ADDR_W-1:2], 2'b00};
            end
            S_MEMWR: begin
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = {aluout_trunc_s[ADDR_W-1:2], 2'b00};
                mem_wdata_d = b_q;
            end
            S_MEMWB, S_RWB, S_AWB, S_BEQ, S_JMP: retire_d = 1'b1;
            default: retire_d = 1'b0;
        endcase
        halted_d = halted_q | (state_d == S_HALT);
    end

    // State, datapath and output registers; reset abandons any pending request at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= 32'd0;
            mdr_q       <= 32'd0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            aluout_q    <= 32'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= 32'd0;
            retire_q    <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            mdr_q       <= mdr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            aluout_q    <= aluout_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            retire_q    <= retire_d;
            halted_q    <= halted_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign pc        = pc_q;
    assign halted    = halted_q;
    // A store completes on its ready cycle, which cannot be known a cycle ahead.
    assign retire    = retire_q | ((state_q == S_MEMWR) & mem_done_s);

endmodule

// File: tb/tb_mc_datapath.sv
module tb_mc_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, mem_we, mem_ready, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

    mc_datapath #(.ADDR_W(32), .RESET_PC(32'h0000_0040)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
        .retire(retire), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_fetch;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    acc_t        acc_q[$];
    int          lat_q[$];
    logic [31:0] mem [0:511];
    int          checks = 0;
    int          failures = 0;
    int          fetch_wait = 0;
    int          data_wait = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Load one instruction word and queue its expected fetch, optional data access and latency.
    task automatic put(input logic [31:0] addr, input logic [31:0] word, input int lat,
                       input bit dat, input bit we, input logic [31:0] daddr, input logic [31:0] wdata);
        mem[addr[10:2]] = word;
        acc_q.push_back('{is_fetch: 1'b1, we: 1'b0, addr: addr, wdata: 32'd0});
        if (dat) acc_q.push_back('{is_fetch: 1'b0, we: we, addr: daddr, wdata: wdata});
        if (lat > 0) lat_q.push_back(lat);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((acc_q.size() != 0 || lat_q.size() != 0) && n < 600) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 600) begin
            failures++;
            $display("FAIL drain_%s: %0d accesses, %0d retires still pending", tag, acc_q.size(), lat_q.size());
            acc_q.delete();
            lat_q.delete();
        end
        @(negedge clk);
    endtask

    // Memory model and access monitor: grants after the configured wait, checks each access.
    int          wcnt = 0;
    logic        hold_we;
    logic [31:0] hold_addr, hold_wdata;
    always @(negedge clk) begin : mem_model
        int   need;
        acc_t e;
        if (reset) begin
            mem_ready = 1'b0;
            wcnt = 0;
        end else begin
            if (mem_ready) begin
                mem_ready = 1'b0;
                wcnt = 0;
            end
            if (mem_req) begin
                if (wcnt == 0) begin
                    hold_we = mem_we; hold_addr = mem_addr; hold_wdata = mem_wdata;
                end else begin
                    chk("hold_addr", mem_addr, hold_addr);
                    chk("hold_we", {31'd0, mem_we}, {31'd0, hold_we});
                    if (hold_we) chk("hold_wdata", mem_wdata, hold_wdata);
                end
                need = (acc_q.size() == 0) ? 1000 : (acc_q[0].is_fetch ? fetch_wait : data_wait);
                if (wcnt >= need) begin
                    e = acc_q.pop_front();
                    chk("acc_addr", mem_addr, e.addr);
                    chk("acc_we", {31'd0, mem_we}, {31'd0, e.we});
                    if (e.we) begin
                        chk("st_wdata", mem_wdata, e.wdata);
                        chk("st_held_cycles", wcnt + 1, data_wait + 1);
                    end
                    mem_rdata = mem[mem_addr[10:2]];
                    if (mem_we) mem[mem_addr[10:2]] = mem_wdata;
                    mem_ready = 1'b1;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // Retire monitor: cycles since the previous retire (or first request) against the queue.
    int cnt = 0;
    bit started = 1'b0;
    always @(negedge clk) begin : retire_mon
        #2;
        if (reset) begin
            started = 1'b0;
            cnt = 0;
        end else begin
            if (mem_req) started = 1'b1;
            if (started) cnt++;
            if (retire) begin
                if (lat_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL retire_unexpected: retire after %0d cycles, none expected", cnt);
                end else begin
                    chk("retire_latency", cnt, lat_q.pop_front());
                end
                cnt = 0;
            end
        end
    end

    initial begin
        int seen;
        reset = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        for (int i = 0; i < 512; i++) mem[i] = 32'd0;

        // Program 1: arithmetic, store/load with 2 data wait cycles, beq, j, self-loop.
        data_wait = 2;
        put(32'h40, 32'h20010005, 4, 0, 0, 0, 0);          // addi $1,$0,5
        put(32'h44, 32'h00211020, 4, 0, 0, 0, 0);          // add  $2,$1,$1   -> 10
        put(32'h48, 32'hAC020008, 6, 1, 1, 32'd8, 32'd10); // sw   $2,8($0)
        put(32'h4C, 32'h8C030008, 7, 1, 0, 32'd8, 0);      // lw   $3,8($0)
        put(32'h50, 32'h00612022, 4, 0, 0, 0, 0);          // sub  $4,$3,$1   -> 5
        put(32'h54, 32'h2006FFFF, 4, 0, 0, 0, 0);          // addi $6,$0,-1
        put(32'h58, 32'h00C1282A, 4, 0, 0, 0, 0);          // slt  $5,$6,$1   -> 1
        put(32'h5C, 32'h00663824, 4, 0, 0, 0, 0);          // and  $7,$3,$6   -> 10
        put(32'h60, 32'h00234025, 4, 0, 0, 0, 0);          // or   $8,$1,$3   -> 15
        put(32'h64, 32'hAC04000C, 6, 1, 1, 32'd12, 32'd5);
        put(32'h68, 32'hAC050010, 6, 1, 1, 32'd16, 32'd1);
        put(32'h6C, 32'hAC070014, 6, 1, 1, 32'd20, 32'd10);
        put(32'h70, 32'hAC080018, 6, 1, 1, 32'd24, 32'd15);
        put(32'h74, 32'h00210020, 4, 0, 0, 0, 0);          // add  $0,$1,$1   (discarded)
        put(32'h78, 32'hAC00001C, 6, 1, 1, 32'd28, 32'd0);
        put(32'h7C, 32'h0026482A, 4, 0, 0, 0, 0);          // slt  $9,$1,$6   -> 0
        put(32'h80, 32'hAC090020, 6, 1, 1, 32'd32, 32'd0);
        put(32'h84, 32'h10260005, 3, 0, 0, 0, 0);          // beq  $1,$6,+5 (not taken)
        put(32'h88, 32'h08000100, 3, 0, 0, 0, 0);          // j    0x100 -> 0x400
        for (int i = 0; i < 3; i++) put(32'h400, 32'h1021FFFF, 3, 0, 0, 0, 0); // beq $1,$1,-1

        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 32'h40);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_retire", {31'd0, retire}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("first_req", {31'd0, mem_req}, 32'd1);
        chk("first_addr", mem_addr, 32'h40);
        drain("prog1");

        // Program 2: illegal opcode halts on cycle 3 and stops requesting.
        reset = 1'b1;
        data_wait = 0;
        put(32'h40, 32'hFC000000, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);                               // cycle 1: fetch
        @(negedge clk);                               // cycle 2: decode
        chk("halt_c2", {31'd0, halted}, 32'd0);
        @(negedge clk);                               // cycle 3
        chk("halt_c3", {31'd0, halted}, 32'd1);
        chk("halt_pc", pc, 32'h44);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_req) seen++;
        end
        chk("halt_no_req", seen, 0);
        drain("prog2");
        reset = 1'b1;
        #1;
        chk("halt_cleared", {31'd0, halted}, 32'd0);

        // Program 3: bne $1,$0,+2 with $1=5.
        put(32'h40, 32'h20010005, 4, 0, 0, 0, 0);
`ifdef MC_DATAPATH_BNE_EN
        put(32'h44, 32'h14200002, 3, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) put(32'h50, 32'h08000014, 3, 0, 0, 0, 0); // j 0x50
`else
        put(32'h44, 32'h14200002, 0, 0, 0, 0, 0);
`endif
        @(negedge clk);
        reset = 1'b0;
        drain("prog3");
        repeat (4) @(negedge clk);
`ifdef MC_DATAPATH_BNE_EN
        chk("bne_halted", {31'd0, halted}, 32'd0);
`else
        chk("bne_halted", {31'd0, halted}, 32'd1);
`endif

        // Program 4: reset while a fetch is pending drops mem_req immediately.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("pend_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_req", {31'd0, mem_req}, 32'd0);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
